// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters,
// common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line comes out of reset already idle.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: recovers frames from rx using a shared oversampling
// enable, presents good bytes with RxDone and flags bad stop bits on frameErr.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boudTick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 RxDone,
  output logic                 frameErr,
  output logic                 RxBusy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DATA_BITS - 1);

  logic                 rxS;
  uartState_t           state, stateNext;
  logic [TW-1:0]        tick, tickNext;
  logic [CW-1:0]        count, countNext;
  logic [DATA_BITS-1:0] shift, shiftNext;
  logic [DATA_BITS-1:0] dataNext;
  logic                 doneNext, errNext;

  uart_sync2 #(.RESET_VALUE(1'b1)) rxSync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxS)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick     <= '0;
      count    <= '0;
      shift    <= '0;
      dataOut  <= '0;
      RxDone   <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state    <= stateNext;
      tick     <= tickNext;
      count    <= countNext;
      shift    <= shiftNext;
      dataOut  <= dataNext;
      RxDone   <= doneNext;
      frameErr <= errNext;
    end
  end

  // Start bit is confirmed at mid-bit; every later sample lands one full bit
  // period on, so the stop bit is taken at its midpoint and the FSM is back in
  // IDLE half a bit early, ready for a gapless next frame.
  always_comb begin
    stateNext = state;
    tickNext  = tick;
    countNext = count;
    shiftNext = shift;
    dataNext  = dataOut;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxS) begin
          stateNext = START;
          tickNext  = '0;
        end
      end
      START: begin
        if (boudTick) begin
          tickNext = tick + 1'b1;
          if (tick == TICK_MID) begin
            if (!rxS) begin
              stateNext = DATA;
              tickNext  = '0;
              countNext = '0;
            end else begin
              stateNext = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (boudTick) begin
          tickNext = tick + 1'b1;
          if (tick == TICK_LAST) begin
            shiftNext = {rxS, shift[DATA_BITS-1:1]};
            tickNext  = '0;
            if (count == COUNT_LAST) begin
              stateNext = STOP;
            end else begin
              countNext = count + 1'b1;
            end
          end
        end
      end
      STOP: begin
        if (boudTick) begin
          tickNext = tick + 1'b1;
          if (tick == TICK_LAST) begin
            stateNext = IDLE;
            if (rxS) begin
              dataNext = shift;
              doneNext = 1'b1;
            end else begin
              errNext = 1'b1;
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign RxBusy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the downstream peer of the UART transmitter on the serial line. It recovers 8N1 frames from the `rx` line using the shared 16x oversampling `boudTick` enable. It presents each good byte on `dataOut` with a one-cycle `RxDone` strobe and flags bad stop bits on `frameErr`. It feeds the receive-side byte consumer, a FIFO or the core's load logic.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVERSAMPLE`, default 16: `boudTick` pulses per bit period; must be even and ≥ 4.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `boudTick` input, 1 bit: one-`clk`-wide enable at OVERSAMPLE × baud rate.
- `rx` input, 1 bit: asynchronous serial line; idle-high.
- `dataOut` output, DATA_BITS: last correctly framed byte; holds until the next good frame.
- `RxDone` output, 1 bit: one-cycle pulse when `dataOut` is updated.
- `frameErr` output, 1 bit: one-cycle pulse when the sampled stop bit is 0.
- `RxBusy` output, 1 bit: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; its output `rxS` has a reset value of 1. All FSM decisions use `rxS` only.
- Registers:
  - `tick`: width log2(OVERSAMPLE).
  - `count`: width log2(DATA_BITS).
  - `shift`: DATA_BITS wide.
  - `state`: 2 bits.
- **IDLE:** when `rxS` == 0, go to START and clear `tick`. No `boudTick` is needed for this transition.
- **START:** on each `boudTick`, increment `tick`. On a `boudTick` with `tick` == OVERSAMPLE/2−1 (mid start bit):
  - If `rxS` == 0: go to DATA and clear `tick` and `count`.
  - Otherwise: treat it as a glitch and return to IDLE with no output.
- **DATA:** on each `boudTick`, increment `tick`. On a `boudTick` with `tick` == OVERSAMPLE−1:
  - Shift right with `rxS` entering at the MSB, and clear `tick`.
  - If `count` == DATA_BITS−1, go to STOP. Otherwise increment `count`.
- **STOP:** on each `boudTick`, increment `tick`. On a `boudTick` with `tick` == OVERSAMPLE−1, sample `rxS`:
  - If 1: load `dataOut` from `shift` and pulse `RxDone`.
  - If 0: pulse `frameErr` and leave `dataOut` unchanged.
  - In both cases go to IDLE.
- Sampling the stop bit at its midpoint returns the FSM to IDLE half a bit early. This guarantees back-to-back frames with zero idle gap are received.
- With `frameErr`, a held-low line (break) causes IDLE→START immediately after. START re-checks and proceeds only if the line is still low at mid-bit. A continuous break therefore produces repeated `frameErr` pulses with `dataOut` unchanged; this is accepted behaviour.
- All counters wrap naturally. No counter advances without `boudTick`.

## Timing
- Reset values:
  - `dataOut` = 0, `RxDone` = 0, `frameErr` = 0, `RxBusy` = 0.
  - FSM = IDLE; `tick`, `count`, `shift` = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is emitted. After release, a line that is still low restarts at START.
- `rx` to `rxS` latency: 2 `clk` cycles.
- `RxDone` and `frameErr` are registered. They are high for exactly the one `clk` cycle after the edge that takes the stop sample, and never both at once.
- `dataOut` changes on the same edge that raises `RxDone`.
- Frame length from the start-bit falling edge to `RxDone` is (DATA_BITS+1)·OVERSAMPLE + OVERSAMPLE/2 ticks, plus 2–3 `clk` cycles.
- `RxBusy` rises the cycle after `rxS` falls and drops with the return to IDLE.

## Structure
- Shared package `uart_pkg`:
  - State encodings IDLE=0, START=1, DATA=2, STOP=3, shared with the transmitter.
  - Default OVERSAMPLE and DATA_BITS constants.
- One sub-module: `uart_sync2`, a 2-flop synchronizer with a parameterized reset value, reset by `rst`.
- Next-state logic is a single combinational block with registered state, matching the transmitter's two-process style.

## Test plan
- **Single frame:** `boudTick` every 4 `clk`; drive 0xA5 as 8N1 → one `RxDone` pulse, `dataOut` = 0xA5, `frameErr` never high.
- **Back-to-back:** 0x00 then 0xFF with no idle gap → two `RxDone` pulses, `dataOut` = 0x00 then 0xFF.
- **Glitch:** `rx` low for 5 ticks then high → FSM returns to IDLE, no `RxDone`, no `frameErr`, `dataOut` unchanged.
- **Framing error:** after a good 0x12, send 0x3C with stop bit 0 → `frameErr` pulses once, `dataOut` stays 0x12, `RxDone` low.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x5A, release, then send 0x81 → no strobe for 0x5A, `dataOut` = 0x81 after the second frame.
- **Loopback:** uart_transmitter `tx` → `rx`, sharing `boudTick`, with 256 random bytes → every byte matches, zero `frameErr`.
